// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master data RAM arbiter.
// Optional build macro: MEM_ARB_STATS_EN (per-requester grant counters).
package mem_port_arbiter_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector; prio names the winner on a tie.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       any,
    output logic       winner
);

    // Lone requester wins outright; on a tie the priority pointer decides.
    always_comb begin
        any    = |req;
        winner = REQ_M0;
        if (req == 2'b11) begin
            winner = prio;
        end else if (req[1]) begin
            winner = REQ_M1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data RAM between requester m0 (CPU) and m1.
// Optional build macro: MEM_ARB_STATS_EN adds saturating 16-bit grant counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter bit          M0_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_wr_sig,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
`ifdef MEM_ARB_STATS_EN
    output logic [CNT_W-1:0]  m0_grant_cnt,
    output logic [CNT_W-1:0]  m1_grant_cnt,
`endif
    output logic              busy
);

    localparam logic PRIO_RST = M0_FIRST ? REQ_M0 : REQ_M1;

    state_t            r_state, w_state_nxt;
    logic              r_wr, w_wr_nxt;
    logic              r_idx, w_idx_nxt;
    logic              r_prio, w_prio_nxt;
    logic              r_m0_gnt, w_m0_gnt_nxt;
    logic              r_m1_gnt, w_m1_gnt_nxt;
    logic              r_m0_rvalid, w_m0_rvalid_nxt;
    logic              r_m1_rvalid, w_m1_rvalid_nxt;
    logic [DATA_W-1:0] r_m0_rdata, w_m0_rdata_nxt;
    logic [DATA_W-1:0] r_m1_rdata, w_m1_rdata_nxt;
    logic              r_ram_wr, w_ram_wr_nxt;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_nxt;
    logic              w_any;
    logic              w_winner;

    rr_pick2 u_pick (
        .req    ({m1_req, m0_req}),
        .prio   (r_prio),
        .any    (w_any),
        .winner (w_winner)
    );

    // Next-state and next-output logic; strobes default low, payload holds.
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_nxt        = r_wr;
        w_idx_nxt       = r_idx;
        w_prio_nxt      = r_prio;
        w_m0_gnt_nxt    = 1'b0;
        w_m1_gnt_nxt    = 1'b0;
        w_m0_rvalid_nxt = 1'b0;
        w_m1_rvalid_nxt = 1'b0;
        w_m0_rdata_nxt  = r_m0_rdata;
        w_m1_rdata_nxt  = r_m1_rdata;
        w_ram_wr_nxt    = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt     = ST_ACCESS;
                    w_idx_nxt       = w_winner;
                    w_wr_nxt        = (w_winner == REQ_M1) ? m1_wr    : m0_wr;
                    w_ram_addr_nxt  = (w_winner == REQ_M1) ? m1_addr  : m0_addr;
                    w_ram_wdata_nxt = (w_winner == REQ_M1) ? m1_wdata : m0_wdata;
                    w_ram_wr_nxt    = w_wr_nxt;
                    w_m0_gnt_nxt    = (w_winner == REQ_M0);
                    w_m1_gnt_nxt    = (w_winner == REQ_M1);
                end
            end
            ST_ACCESS: begin
                w_prio_nxt  = ~r_idx;
                w_state_nxt = r_wr ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (r_idx == REQ_M0) begin
                    w_m0_rdata_nxt  = ram_rd_data;
                    w_m0_rvalid_nxt = 1'b1;
                end else begin
                    w_m1_rdata_nxt  = ram_rd_data;
                    w_m1_rvalid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr        <= 1'b0;
            r_idx       <= REQ_M0;
            r_prio      <= PRIO_RST;
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_ram_wr    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr        <= w_wr_nxt;
            r_idx       <= w_idx_nxt;
            r_prio      <= w_prio_nxt;
            r_m0_gnt    <= w_m0_gnt_nxt;
            r_m1_gnt    <= w_m1_gnt_nxt;
            r_m0_rvalid <= w_m0_rvalid_nxt;
            r_m1_rvalid <= w_m1_rvalid_nxt;
            r_m0_rdata  <= w_m0_rdata_nxt;
            r_m1_rdata  <= w_m1_rdata_nxt;
            r_ram_wr    <= w_ram_wr_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0] r_m0_cnt, r_m1_cnt;

    // Saturating grant counters, bumped once per gnt pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m0_cnt <= '0;
            r_m1_cnt <= '0;
        end else begin
            if (r_m0_gnt && (r_m0_cnt != CNT_MAX)) r_m0_cnt <= r_m0_cnt + CNT_W'(1);
            if (r_m1_gnt && (r_m1_cnt != CNT_MAX)) r_m1_cnt <= r_m1_cnt + CNT_W'(1);
        end
    end

    assign m0_grant_cnt = r_m0_cnt;
    assign m1_grant_cnt = r_m1_cnt;
`endif

    assign m0_gnt      = r_m0_gnt;
    assign m1_gnt      = r_m1_gnt;
    assign m0_rvalid   = r_m0_rvalid;
    assign m1_rvalid   = r_m1_rvalid;
    assign m0_rdata    = r_m0_rdata;
    assign m1_rdata    = r_m1_rdata;
    assign ram_wr_sig  = r_ram_wr;
    assign ram_addr    = r_ram_addr;
    assign ram_wr_data = r_ram_wdata;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a one-cycle-latency RAM model.
// Build with MEM_ARB_STATS_EN defined to also check the grant counters.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_wr_sig;
    logic [31:0] ram_addr, ram_wr_data;
    logic [31:0] ram_rd_data = '0;
    logic        busy;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] m0_grant_cnt, m1_grant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    int          gq[$];
    logic [63:0] wq[$];
    logic [63:0] rq0[$];
    logic [63:0] rq1[$];

    logic [31:0] mem     [256];
    bit          written [256];

    localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req      (m0_req),
        .m0_wr       (m0_wr),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_wr       (m1_wr),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .ram_wr_sig  (ram_wr_sig),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data),
`ifdef MEM_ARB_STATS_EN
        .m0_grant_cnt(m0_grant_cnt),
        .m1_grant_cnt(m1_grant_cnt),
`endif
        .busy        (busy)
    );

    // RAM model: unwritten words read as 0xCAFE00xx, data one cycle after address.
    always @(posedge clk) begin
        if (ram_wr_sig) begin
            mem[ram_addr[7:0]]     <= ram_wr_data;
            written[ram_addr[7:0]] <= 1'b1;
        end
        ram_rd_data <= written[ram_addr[7:0]] ? mem[ram_addr[7:0]]
                                               : (32'hCAFE_0000 | {24'h0, ram_addr[7:0]});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every output strobe pops and checks its scoreboard entry.
    task automatic monitor();
        int          e;
        logic [63:0] x;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (m0_gnt) begin
                    e = (gq.size() != 0) ? gq.pop_front() : 2;
                    chk("gnt_port_m0", 64'(0), 64'(e));
                end
                if (m1_gnt) begin
                    e = (gq.size() != 0) ? gq.pop_front() : 2;
                    chk("gnt_port_m1", 64'(1), 64'(e));
                end
                if (ram_wr_sig) begin
                    x = (wq.size() != 0) ? wq.pop_front() : NONE;
                    chk("ram_write", {ram_addr, ram_wr_data}, x);
                end
                if (m0_rvalid) begin
                    x = (rq0.size() != 0) ? rq0.pop_front() : NONE;
                    chk("m0_rdata", {32'h0, m0_rdata}, x);
                end
                if (m1_rvalid) begin
                    x = (rq1.size() != 0) ? rq1.pop_front() : NONE;
                    chk("m1_rdata", {32'h0, m1_rdata}, x);
                end
            end
        end
    endtask

    // One transaction from an idle arbiter; lat = cycle of gnt counting req cycle as 1.
    task automatic do_txn(input bit port, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          output int lat);
        bit got;
        @(posedge clk); #1;
        gq.push_back(int'(port));
        if (wr) wq.push_back({addr, wdata});
        else if (port) rq1.push_back({32'h0, exp_rd});
        else rq0.push_back({32'h0, exp_rd});
        if (port) begin m1_req = 1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata; end
        else      begin m0_req = 1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata; end
        lat = 0;
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (port ? m1_gnt : m0_gnt) begin
                lat = i + 1;
                got = 1;
                break;
            end
        end
        m0_req = 0;
        m1_req = 0;
        chk("gnt_seen", 64'(got), 64'(1));
        @(posedge clk); #1;
        chk("busy_after_access", 64'(busy), 64'(!wr));
        if (!wr) begin
            @(posedge clk); #1;
            chk("busy_after_resp", 64'(busy), 64'(0));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   64'(busy), 64'(0));
        chk({tag, "_gnt"},    64'({m0_gnt, m1_gnt}), 64'(0));
        chk({tag, "_rvalid"}, 64'({m0_rvalid, m1_rvalid}), 64'(0));
        chk({tag, "_ram"},    {31'h0, ram_wr_sig, ram_addr}, 64'(0));
        chk({tag, "_wdata"},  64'(ram_wr_data), 64'(0));
        chk({tag, "_rdata"},  {m0_rdata, m1_rdata}, 64'(0));
    endtask

    initial begin
        int  lat;
        int  n0, n1;
        bit  got;
        reset = 1;
        m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk_reset_vals("rst0");

        // m0 write then read back; gnt in the second cycle of the transaction
        do_txn(0, 1, 32'h10, 32'hDEAD_BEEF, 32'h0, lat);
        chk("m0_wr_gnt_cycle", 64'(lat), 64'(2));
        do_txn(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, lat);
        chk("m0_rd_gnt_cycle", 64'(lat), 64'(2));

        // m1 write 55 to 0x40, m0 reads it, m1 reads it back too
        do_txn(1, 1, 32'h40, 32'h37, 32'h0, lat);
        do_txn(0, 0, 32'h40, 32'h0, 32'h37, lat);
        do_txn(1, 0, 32'h40, 32'h0, 32'h37, lat);
        @(posedge clk); #1;
        chk("m0_rdata_hold", 64'(m0_rdata), 64'h37);
`ifdef MEM_ARB_STATS_EN
        chk("m0_grant_cnt", 64'(m0_grant_cnt), 64'd3);
        chk("m1_grant_cnt", 64'(m1_grant_cnt), 64'd2);
`endif

        // Both requesting reads continuously from reset: m0,m1,m0,m1
        @(posedge clk); #1;
        reset = 1;
        m0_req = 1; m0_wr = 0; m0_addr = 32'h20;
        m1_req = 1; m1_wr = 0; m1_addr = 32'h30;
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
        rq0.push_back(64'hCAFE_0020); rq0.push_back(64'hCAFE_0020);
        rq1.push_back(64'hCAFE_0030); rq1.push_back(64'hCAFE_0030);
        @(posedge clk); #1;
        chk_reset_vals("rst1");
`ifdef MEM_ARB_STATS_EN
        chk("cnt_cleared", {m0_grant_cnt, m1_grant_cnt}, 64'(0));
`endif
        @(posedge clk); #1;
        reset = 0;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 40 && (n0 < 2 || n1 < 2); i++) begin
            @(posedge clk); #1;
            if (m0_gnt) begin n0++; if (n0 == 2) m0_req = 0; end
            if (m1_gnt) begin n1++; if (n1 == 2) m1_req = 0; end
        end
        chk("alt_grants", 64'({n0[7:0], n1[7:0]}), 64'h0202);
        repeat (4) @(posedge clk);

        // Reset during the RESP cycle of an m1 read abandons it
        #1;
        gq.push_back(1);
        m1_req = 1; m1_wr = 0; m1_addr = 32'h30;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m1_gnt) begin got = 1; break; end
        end
        m1_req = 0;
        chk("rst_rd_gnt", 64'(got), 64'(1));
        @(posedge clk); #1;
        chk("in_resp_busy", 64'(busy), 64'(1));
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk_reset_vals("rst2");
        repeat (4) @(posedge clk);

        // Served normally after the abandoned read
        do_txn(1, 0, 32'h20, 32'h0, 32'hCAFE_0020, lat);
        chk("m1_after_rst_gnt_cycle", 64'(lat), 64'(2));
        repeat (3) @(posedge clk);

        chk("gq_drained", 64'(gq.size()), 64'(0));
        chk("wq_drained", 64'(wq.size()), 64'(0));
        chk("rq_drained", 64'(rq0.size() + rq1.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter that shares the single-port data RAM between the CPU load/store port (m0) and a second master (m1, e.g. program loader or debug port). Accepts one request at a time and drives the RAM's write-enable, address and write-data lines. Returns read data with a valid pulse. Sits between the cpu and ram instances at the top level, replacing their direct connection.

Parameters:
ADDR_W, 32, address width of requester and RAM address buses
DATA_W, 32, data width of read/write data buses
M0_FIRST, 1, requester that holds priority out of reset (1 = m0, 0 = m1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  m0 request; held until m0_gnt
m0_wr  in  1  m0 direction (1 = write, 0 = read); stable while m0_req
m0_addr  in  ADDR_W  m0 address
m0_wdata  in  DATA_W  m0 write data
m0_gnt  out  1  one-cycle pulse: m0 request issued to RAM
m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
m0_rdata  out  DATA_W  m0 read data, held until next m0 read
m1_*  same set as m0_* for requester 1
ram_wr_sig  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wr_data  out  DATA_W  RAM write data
ram_rd_data  in  DATA_W  RAM read data, valid one cycle after address
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`; synchronous, active-high `reset`. Reset applies on the rising edge.
- Reset values: state=IDLE; all gnt/rvalid=0; ram_wr_sig=0; ram_addr=0; ram_wr_data=0; m0_rdata=m1_rdata=0; priority pointer=M0_FIRST. A reset mid-operation abandons the transaction with no rvalid and no RAM write.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: remain in IDLE.
- IDLE, any request: pick the winner, latch its wr/addr/wdata and its index into registers, then go to ACCESS.
- Winner selection:
  - Exactly one request pending: that requester wins.
  - Both pending: the requester named by the priority pointer wins.
- ACCESS (one cycle):
  - ram_addr/ram_wr_data come from the latched request; ram_wr_sig = latched wr.
  - Winner's gnt = 1 for this cycle only.
  - Priority pointer flips to the loser.
  - Next state: RESP if read, IDLE if write.
- RESP (one cycle):
  - Capture ram_rd_data into the winner's rdata register.
  - The winner's rvalid is asserted the cycle after RESP, as a registered pulse.
  - Next state: IDLE.
- ram_wr_sig is 0 in every state except ACCESS-with-write. ram_addr/ram_wr_data hold their last values outside ACCESS.
- Latency from req to gnt: 2 cycles.
- Throughput: write occupies 2 cycles (IDLE, ACCESS); read occupies 3 cycles (IDLE, ACCESS, RESP), and rvalid lands in the following IDLE cycle.
- A requester that drops req before gnt is a protocol violation; its latched request still completes.
- A new request may be accepted in the same IDLE cycle in which the previous read's rvalid is high.
- The losing requester keeps req high and is served next. It waits no more than one transaction (starvation-free).
- Address and data pass through unmodified; no width conversion.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - Adds output ports m0_grant_cnt and m1_grant_cnt, each 16 bits.
  - Each counter increments on its own gnt pulse, saturates at 16'hFFFF, and clears on reset.
- When undefined: ports and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header (alongside the existing parameters header): FSM state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2, plus requester index constants REQ_M0=1'b0, REQ_M1=1'b1.
- One natural sub-module, rr_pick2: a combinational two-way round-robin selector. Inputs: req[1:0], prio. Outputs: any, winner.

Test Plan:
- Reset, then single m0 write (addr 0x10, data 0xDEADBEEF) -> m0_gnt pulses 2 cycles after req; ram_wr_sig=1 with addr 0x10, data 0xDEADBEEF for exactly one cycle; busy back low next cycle.
- m0 read of 0x10 after that write -> m0_rvalid pulses exactly once, m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- m0 and m1 both request reads continuously from reset (M0_FIRST=1) -> grant order m0,m1,m0,m1 across 4 transactions; never two consecutive grants to the same port.
- m1 writes 0x0000_0037 (55) to 0x40 while m0 is idle, then m0 reads 0x40 -> m0_rdata=55.
- Assert reset in a RESP cycle of an m1 read -> no m1_rvalid; outputs at reset values; next m1 request is still served correctly.
- With MEM_ARB_STATS_EN, perform 3 m0 and 2 m1 transactions -> m0_grant_cnt=3, m1_grant_cnt=2; counters return to 0 after reset.
